// File: rtl/traffic_light_guard_if.sv
// Light-code bundle between the traffic light controller, the safety guard and the lamp drivers.
// The master drives controller codes and clear_fault; the slave returns guarded lamps and fault status.
interface traffic_light_guard_if;
   logic [2:0] north_in;
   logic [2:0] south_in;
   logic [2:0] east_in;
   logic [2:0] west_in;
   logic       clear_fault;
   logic [2:0] north;
   logic [2:0] south;
   logic [2:0] east;
   logic [2:0] west;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] fault_count;

   modport master (
      output north_in, south_in, east_in, west_in, clear_fault,
      input  north, south, east, west, fault, fault_code, fault_count
   );

   modport slave (
      input  north_in, south_in, east_in, west_in, clear_fault,
      output north, south, east, west, fault, fault_code, fault_count
   );
endinterface

// File: rtl/traffic_light_guard.sv
// Safety guard between the light controller and the lamp drivers: registers the four codes,
// latches the first violation it sees and holds every road at red until software clears it.
module traffic_light_guard #(
   parameter int MIN_YELLOW  = 2,
   parameter int MAX_HOLD    = 64,
   parameter int RECOVER_CYC = 4
) (
   input logic                  clock,
   input logic                  reset,
   traffic_light_guard_if.slave bus
);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam int YEL_W  = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
   localparam int REC_W  = (RECOVER_CYC > 0) ? $clog2(RECOVER_CYC + 1) : 1;

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [YEL_W-1:0]  YEL_MAX  = YEL_W'(MIN_YELLOW);
   localparam logic [REC_W-1:0]  REC_LOAD = REC_W'(RECOVER_CYC);

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   typedef enum logic [1:0] {MONITOR, FAULT, RECOVER} state_t;

   state_t            state;
   logic [3:0][2:0]   cur;
   logic [3:0][2:0]   prev;
   logic [3:0][2:0]   lamps;
   logic [YEL_W-1:0]  yel_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REC_W-1:0]  rec_cnt;
   logic              skip_seq;
   logic              fault_reg;
   logic [2:0]        code_reg;
   logic [7:0]        count_reg;

   logic              bad_code;
   logic              bad_seq;
   logic              short_yel;
   logic              any_yellow;
   logic [2:0]        non_red;
   logic [2:0]        fault_now;

   assign cur = {bus.north_in, bus.south_in, bus.east_in, bus.west_in};

   always_comb begin
      bad_code   = 1'b0;
      bad_seq    = 1'b0;
      short_yel  = 1'b0;
      any_yellow = 1'b0;
      non_red    = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (cur[i] != RED && cur[i] != YELLOW && cur[i] != GREEN)
            bad_code = 1'b1;
         if (cur[i] != RED)
            non_red = non_red + 3'd1;
         if (cur[i] == YELLOW)
            any_yellow = 1'b1;
         if (!(cur[i] == prev[i] ||
               (prev[i] == RED    && cur[i] == GREEN)  ||
               (prev[i] == GREEN  && cur[i] == YELLOW) ||
               (prev[i] == YELLOW && cur[i] == RED)))
            bad_seq = 1'b1;
         if (prev[i] == YELLOW && cur[i] == RED && yel_cnt < YEL_MAX)
            short_yel = 1'b1;
      end

      // Lowest cause wins; sequence checks are suppressed right after recovery
      fault_now = 3'd0;
      if (bad_code)
         fault_now = 3'd1;
      else if (non_red > 3'd1)
         fault_now = 3'd2;
      else if (!skip_seq && bad_seq)
         fault_now = 3'd3;
      else if (!skip_seq && short_yel)
         fault_now = 3'd4;
      else if (hold_cnt == HOLD_MAX)
         fault_now = 3'd5;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= MONITOR;
         prev      <= {4{RED}};
         lamps     <= {4{RED}};
         yel_cnt   <= '0;
         hold_cnt  <= '0;
         rec_cnt   <= '0;
         skip_seq  <= 1'b0;
         fault_reg <= 1'b0;
         code_reg  <= 3'd0;
         count_reg <= 8'd0;
      end else begin
         case (state)
            MONITOR: begin
               prev     <= cur;
               skip_seq <= 1'b0;
               if (any_yellow)
                  yel_cnt <= (yel_cnt == YEL_MAX) ? yel_cnt : yel_cnt + 1'b1;
               else
                  yel_cnt <= '0;
               if (cur == prev)
                  hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
               else
                  hold_cnt <= '0;
               if (fault_now != 3'd0) begin
                  state     <= FAULT;
                  lamps     <= {4{RED}};
                  fault_reg <= 1'b1;
                  code_reg  <= fault_now;
                  if (count_reg != 8'hFF)
                     count_reg <= count_reg + 8'd1;
               end else begin
                  lamps <= cur;
               end
            end
            FAULT: begin
               lamps <= {4{RED}};
               if (bus.clear_fault) begin
                  state   <= RECOVER;
                  rec_cnt <= REC_LOAD;
               end
            end
            RECOVER: begin
               lamps <= {4{RED}};
               // Leaving on the count's last tick keeps exactly RECOVER_CYC all-red cycles
               if (rec_cnt == '0 || rec_cnt == REC_W'(1)) begin
                  state     <= MONITOR;
                  fault_reg <= 1'b0;
                  code_reg  <= 3'd0;
                  prev      <= cur;
                  yel_cnt   <= '0;
                  hold_cnt  <= '0;
                  skip_seq  <= 1'b1;
               end else begin
                  rec_cnt <= rec_cnt - 1'b1;
               end
            end
            default: state <= MONITOR;
         endcase
      end
   end

   assign bus.north       = lamps[3];
   assign bus.south       = lamps[2];
   assign bus.east        = lamps[1];
   assign bus.west        = lamps[0];
   assign bus.fault       = fault_reg;
   assign bus.fault_code  = code_reg;
   assign bus.fault_count = count_reg;
endmodule

// File: tb/tb_traffic_light_guard.sv
// Directed bench for traffic_light_guard: a rule-level model is compared every cycle,
// and hand-computed literals pin the model at the key points of each scenario.
module tb_traffic_light_guard;
   localparam int MIN_YELLOW  = 2;
   localparam int MAX_HOLD    = 64;
   localparam int RECOVER_CYC = 4;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic clock = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   traffic_light_guard_if bus();

   traffic_light_guard #(
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_HOLD   (MAX_HOLD),
      .RECOVER_CYC(RECOVER_CYC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Rule-level model: fault bookkeeping, run lengths and recovery countdown
   logic [3:0][2:0] m_prev;
   logic [3:0][2:0] exp_lamp;
   logic            exp_fault;
   logic [2:0]      exp_code;
   int              exp_count;
   int              yel_run, same_run, rec_left;
   bit              m_faulted, m_recovering, m_skip;

   function automatic logic [2:0] next_colour(input logic [2:0] c);
      case (c)
         R:       return G;
         G:       return Y;
         Y:       return R;
         default: return 3'b111;
      endcase
   endfunction

   task automatic model_reset();
      m_prev = {4{R}}; exp_lamp = {4{R}};
      exp_fault = 1'b0; exp_code = 3'd0; exp_count = 0;
      yel_run = 0; same_run = 0; rec_left = 0;
      m_faulted = 1'b0; m_recovering = 1'b0; m_skip = 1'b0;
   endtask

   task automatic model_step();
      logic [3:0][2:0] now_in;
      bit f_code, f_conf, f_seq, f_short, any_y;
      int non_red;
      now_in = {bus.north_in, bus.south_in, bus.east_in, bus.west_in};
      if (m_recovering) begin
         exp_lamp = {4{R}};
         rec_left--;
         if (rec_left == 0) begin
            m_recovering = 1'b0; m_faulted = 1'b0;
            exp_fault = 1'b0; exp_code = 3'd0;
            m_prev = now_in; yel_run = 0; same_run = 0; m_skip = 1'b1;
         end
      end else if (m_faulted) begin
         exp_lamp = {4{R}};
         if (bus.clear_fault) begin
            m_recovering = 1'b1;
            rec_left = RECOVER_CYC;
         end
      end else begin
         f_code = 0; f_seq = 0; f_short = 0; any_y = 0; non_red = 0;
         for (int i = 0; i < 4; i++) begin
            if (now_in[i] != R && now_in[i] != Y && now_in[i] != G) f_code = 1;
            if (now_in[i] != R) non_red++;
            if (now_in[i] == Y) any_y = 1;
            if (now_in[i] != m_prev[i] && now_in[i] != next_colour(m_prev[i])) f_seq = 1;
            if (m_prev[i] == Y && now_in[i] == R && yel_run < MIN_YELLOW) f_short = 1;
         end
         f_conf = (non_red > 1);
         if (m_skip) begin
            f_seq = 0;
            f_short = 0;
         end
         exp_lamp = now_in;
         if (f_code || f_conf || f_seq || f_short || same_run >= MAX_HOLD) begin
            exp_code  = f_code ? 3'd1 : f_conf ? 3'd2 : f_seq ? 3'd3 : f_short ? 3'd4 : 3'd5;
            exp_fault = 1'b1;
            exp_lamp  = {4{R}};
            m_faulted = 1'b1;
            if (exp_count < 255) exp_count++;
         end
         same_run = (now_in == m_prev) ? same_run + 1 : 0;
         yel_run  = any_y ? yel_run + 1 : 0;
         m_prev   = now_in;
         m_skip   = 1'b0;
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   // Per-cycle comparison against the model, sampled away from the active edge
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         vectors++;
         if ({bus.north, bus.south, bus.east, bus.west, bus.fault, bus.fault_code, bus.fault_count}
             !== {exp_lamp, exp_fault, exp_code, 8'(exp_count)}) begin
            miscompares++;
            $display("[TB] FAIL model_cycle t=%0t got lamps=%b_%b_%b_%b f=%b c=%0d n=%0d want lamps=%b f=%b c=%0d n=%0d",
                     $time, bus.north, bus.south, bus.east, bus.west, bus.fault, bus.fault_code,
                     bus.fault_count, exp_lamp, exp_fault, exp_code, exp_count);
         end
      end
   end

   task automatic check_output(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] n, input logic [2:0] s,
                                 input logic [2:0] e, input logic [2:0] w, input logic clr);
      @(negedge clock);
      bus.north_in = n; bus.south_in = s; bus.east_in = e; bus.west_in = w;
      bus.clear_fault = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      bus.north_in = R; bus.south_in = R; bus.east_in = R; bus.west_in = R;
      bus.clear_fault = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.north_in = R; bus.south_in = R; bus.east_in = R; bus.west_in = R;
      bus.clear_fault = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_output("reset_north", int'(bus.north), 4);
      check_output("reset_fault", int'(bus.fault), 0);
      check_output("reset_code", int'(bus.fault_code), 0);
      check_output("reset_count", int'(bus.fault_count), 0);
      @(negedge clock);
      reset = 1'b1;

      // Legal rotation N green -> yellow -> red, then E green
      apply_stimulus(G, R, R, R, 0);
      check_output("rot_north_green", int'(bus.north), 1);
      apply_stimulus(G, R, R, R, 0);
      apply_stimulus(G, R, R, R, 0);
      apply_stimulus(Y, R, R, R, 0);
      apply_stimulus(Y, R, R, R, 0);
      check_output("rot_north_yellow", int'(bus.north), 2);
      apply_stimulus(R, R, R, R, 0);
      apply_stimulus(R, R, G, R, 0);
      check_output("rot_east_green", int'(bus.east), 1);
      check_output("rot_fault", int'(bus.fault), 0);
      check_output("rot_code", int'(bus.fault_code), 0);

      // Conflict with a same-cycle clear: the fault wins and stays latched
      do_reset();
      apply_stimulus(G, R, G, R, 1);
      check_output("conf_north", int'(bus.north), 4);
      check_output("conf_east", int'(bus.east), 4);
      check_output("conf_fault", int'(bus.fault), 1);
      check_output("conf_code", int'(bus.fault_code), 2);
      check_output("conf_count", int'(bus.fault_count), 1);
      for (int i = 0; i < 6; i++) apply_stimulus(R, R, R, R, 0);
      check_output("conf_still_fault", int'(bus.fault), 1);

      // Green straight to red, then further conflicts while latched
      do_reset();
      apply_stimulus(G, R, R, R, 0);
      apply_stimulus(R, R, R, R, 0);
      check_output("g2r_code", int'(bus.fault_code), 3);
      for (int i = 0; i < 10; i++) apply_stimulus(G, R, G, R, 0);
      check_output("g2r_count", int'(bus.fault_count), 1);
      check_output("g2r_code_kept", int'(bus.fault_code), 3);
      check_output("g2r_north_red", int'(bus.north), 4);

      // Short yellow faults; a full-length yellow does not
      do_reset();
      apply_stimulus(G, R, R, R, 0);
      apply_stimulus(Y, R, R, R, 0);
      apply_stimulus(R, R, R, R, 0);
      check_output("short_y_code", int'(bus.fault_code), 4);
      do_reset();
      apply_stimulus(G, R, R, R, 0);
      apply_stimulus(Y, R, R, R, 0);
      apply_stimulus(Y, R, R, R, 0);
      apply_stimulus(R, R, R, R, 0);
      check_output("long_y_fault", int'(bus.fault), 0);

      // Illegal code beats conflict; then clear and recover
      do_reset();
      apply_stimulus(3'b011, G, R, R, 0);
      check_output("illegal_code", int'(bus.fault_code), 1);
      apply_stimulus(R, R, R, R, 1);
      check_output("rec_fault_1", int'(bus.fault), 1);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(R, R, R, R, 0);
         check_output("rec_fault_held", int'(bus.fault), 1);
      end
      apply_stimulus(G, R, R, R, 0);
      check_output("rec_done_fault", int'(bus.fault), 0);
      check_output("rec_done_code", int'(bus.fault_code), 0);
      check_output("rec_done_count", int'(bus.fault_count), 1);
      apply_stimulus(R, R, R, R, 0);
      check_output("rec_skip_seq", int'(bus.fault), 0);
      apply_stimulus(G, R, R, R, 0);
      check_output("rec_north_green", int'(bus.north), 1);

      // Stuck tuple, then asynchronous reset while faulted
      do_reset();
      for (int i = 0; i < 65; i++) apply_stimulus(G, R, R, R, 0);
      check_output("stuck_before", int'(bus.fault), 0);
      apply_stimulus(G, R, R, R, 0);
      check_output("stuck_code", int'(bus.fault_code), 5);
      check_output("stuck_count", int'(bus.fault_count), 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check_output("async_count", int'(bus.fault_count), 0);
      check_output("async_fault", int'(bus.fault), 0);
      check_output("async_north", int'(bus.north), 4);
      @(negedge clock);
      reset = 1'b1;
      apply_stimulus(R, R, R, R, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
